// File: rtl/cmm_stream_mult.sv
// Handshaked SIZExSIZE complex matrix multiplier: C = R*SH or C = R*SH^H.
// LANES time-shared complex MACs; result is rounded down by FRAC bits and saturated.
module cmm_stream_mult #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 32,
    parameter int FRAC  = 0,
    parameter int LANES = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [WIDTH*SIZE*SIZE-1:0]  s_axis_r_tdata,
    input  logic [WIDTH*SIZE*SIZE-1:0]  s_axis_sh_tdata,
    input  logic                        s_axis_tuser,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [WIDTH*SIZE*SIZE-1:0]  m_axis_tdata,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        busy
);

    localparam int HW     = WIDTH / 2;
    localparam int DW     = WIDTH * SIZE * SIZE;
    localparam int GROUPS = SIZE * SIZE / LANES;
    localparam int ACCW   = WIDTH + $clog2(SIZE) + 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int KW     = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(SIZE - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-HW+1){1'b0}}, {(HW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-HW+1){1'b1}}, {(HW-1){1'b0}}};

    if ((SIZE * SIZE) % LANES != 0) begin : g_bad_lanes
        $error("cmm_stream_mult: SIZE*SIZE must be a multiple of LANES");
    end

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUTPUT} state_e;

    state_e                 state_q, state_d;
    logic [DW-1:0]          r_q, r_d, sh_q, sh_d, tdata_q, tdata_d;
    logic                   mode_q, mode_d;
    logic                   s_ready_q, s_ready_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_user_q, m_user_d;
    logic [GW-1:0]          g_q, g_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [ACCW-1:0] acc_re_q [LANES];
    logic signed [ACCW-1:0] acc_im_q [LANES];
    logic signed [ACCW-1:0] acc_re_d [LANES];
    logic signed [ACCW-1:0] acc_im_d [LANES];

    logic accept, last_term, last_group;

    assign accept     = s_axis_tvalid && s_ready_q;
    assign last_term  = (k_q == K_LAST);
    assign last_group = (g_q == G_LAST);

    function automatic logic signed [ACCW-1:0] sext(input logic [HW-1:0] v);
        return {{(ACCW-HW){v[HW-1]}}, v};
    endfunction

    // Returns {saturated, value}; the shift floors because the accumulator is signed.
    function automatic logic [HW:0] saturate(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_MAX) return {1'b1, SAT_MAX[HW-1:0]};
        if (s < SAT_MIN) return {1'b1, SAT_MIN[HW-1:0]};
        return {1'b0, s[HW-1:0]};
    endfunction

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            sh_q      <= '0;
            tdata_q   <= '0;
            mode_q    <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_user_q  <= 1'b0;
            g_q       <= '0;
            k_q       <= '0;
            // NOTE: the lane accumulators are few and small, so they are reset like ordinary flops.
            for (int l = 0; l < LANES; l++) begin
                acc_re_q[l] <= '0;
                acc_im_q[l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            sh_q      <= sh_d;
            tdata_q   <= tdata_d;
            mode_q    <= mode_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_user_q  <= m_user_d;
            g_q       <= g_d;
            k_q       <= k_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_COMPUTE;
            S_COMPUTE: if (last_term && last_group) state_d = S_OUTPUT;
            S_OUTPUT:  if (m_axis_tready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        int e, ii, jj, kk;
        logic [WIDTH-1:0]       a, b;
        logic signed [ACCW-1:0] ar, ai, br, bi, p_re, p_im, sum_re, sum_im;
        logic [HW:0]            sat_re, sat_im;

        // NOTE: every target gets a default here, so no path can infer a latch.
        r_d       = r_q;
        sh_d      = sh_q;
        mode_d    = mode_q;
        tdata_d   = tdata_q;
        m_user_d  = m_user_q;
        m_valid_d = m_valid_q;
        s_ready_d = 1'b0;
        g_d       = g_q;
        k_d       = k_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        e = 0; ii = 0; jj = 0; kk = 0;
        a = '0; b = '0;
        ar = '0; ai = '0; br = '0; bi = '0;
        p_re = '0; p_im = '0; sum_re = '0; sum_im = '0;
        sat_re = '0; sat_im = '0;

        case (state_q)
            S_IDLE: begin
                s_ready_d = !accept;
                if (accept) begin
                    r_d      = s_axis_r_tdata;
                    sh_d     = s_axis_sh_tdata;
                    mode_d   = s_axis_tuser;
                    m_user_d = 1'b0;
                    g_d      = '0;
                    k_d      = '0;
                end
            end
            S_COMPUTE: begin
                for (int l = 0; l < LANES; l++) begin
                    e  = int'(g_q) * LANES + l;
                    ii = e / SIZE;
                    jj = e % SIZE;
                    kk = int'(k_q);
                    a  = r_q[WIDTH*(ii*SIZE+kk) +: WIDTH];
                    b  = mode_q ? sh_q[WIDTH*(jj*SIZE+kk) +: WIDTH]
                                : sh_q[WIDTH*(kk*SIZE+jj) +: WIDTH];
                    ar = sext(a[HW-1:0]);
                    ai = sext(a[WIDTH-1:HW]);
                    br = sext(b[HW-1:0]);
                    // Conjugate after widening so that an imag of -2^(HW-1) cannot overflow.
                    bi = mode_q ? -sext(b[WIDTH-1:HW]) : sext(b[WIDTH-1:HW]);
                    p_re   = ar * br - ai * bi;
                    p_im   = ar * bi + ai * br;
                    sum_re = (k_q == '0) ? p_re : acc_re_q[l] + p_re;
                    sum_im = (k_q == '0) ? p_im : acc_im_q[l] + p_im;
                    acc_re_d[l] = sum_re;
                    acc_im_d[l] = sum_im;
                    if (last_term) begin
                        sat_re = saturate(sum_re);
                        sat_im = saturate(sum_im);
                        tdata_d[WIDTH*e +: WIDTH] = {sat_im[HW-1:0], sat_re[HW-1:0]};
                        m_user_d = m_user_d | sat_re[HW] | sat_im[HW];
                    end
                end
                if (last_term) begin
                    k_d = '0;
                    g_d = last_group ? '0 : g_q + 1'b1;
                    if (last_group) m_valid_d = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (m_axis_tready) begin
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s_axis_tready = s_ready_q;
        m_axis_tvalid = m_valid_q;
        m_axis_tuser  = m_user_q;
        m_axis_tdata  = tdata_q;
        busy          = (state_q != S_IDLE);
    end

endmodule
